// File: rtl/tinyalu_arbiter.sv
// -----------------------------------------------------------------------------
// tinyalu_arbiter
//   Shares a single TinyALU between NREQ requesters. A round-robin pick in IDLE
//   grants one requester and captures its operands. The arbiter then holds
//   alu_start and the operands steady until alu_done arrives or the timeout
//   expires. The 16-bit result goes back to the winner as a one-cycle
//   rsp_valid pulse.
//
// Ports
//   clk_i, reset_i        clock, synchronous active-high reset
//   req_i[NREQ]           pending request per requester
//   req_a_i/req_b_i       8-bit operands, requester i at slice i*8 +: 8
//   req_op_i              3-bit opcode, requester i at slice i*3 +: 3
//   grant_o[NREQ]         one-hot pulse in the IDLE cycle the request is taken
//   rsp_valid_o[NREQ]     one-hot pulse with rsp_result_o / rsp_error_o
//   alu_start_o/a/b/op    TinyALU command side
//   alu_done_i/result_i   TinyALU completion side
//   busy_o                FSM is not IDLE
//   spurious_done_o       sticky: alu_done_i seen outside ISSUE
// -----------------------------------------------------------------------------
module tinyalu_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 31
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [NREQ-1:0]   req_i,
    input  logic [8*NREQ-1:0] req_a_i,
    input  logic [8*NREQ-1:0] req_b_i,
    input  logic [3*NREQ-1:0] req_op_i,
    output logic [NREQ-1:0]   grant_o,
    output logic [NREQ-1:0]   rsp_valid_o,
    output logic [15:0]       rsp_result_o,
    output logic              rsp_error_o,
    output logic              alu_start_o,
    output logic [7:0]        alu_a_o,
    output logic [7:0]        alu_b_o,
    output logic [2:0]        alu_op_o,
    input  logic              alu_done_i,
    input  logic [15:0]       alu_result_i,
    output logic              busy_o,
    output logic              spurious_done_o
);

    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_e;

    state_e            state_q;
    logic [IDW-1:0]    rr_ptr_q;
    logic [IDW-1:0]    id_q;
    logic [CW-1:0]     cnt_q;
    logic              alu_start_q;
    logic [7:0]        alu_a_q;
    logic [7:0]        alu_b_q;
    logic [2:0]        alu_op_q;
    logic [NREQ-1:0]   rsp_valid_q;
    logic [15:0]       rsp_result_q;
    logic              rsp_error_q;
    logic              spurious_q;

    // Per-requester views of the flat operand buses.
    logic [7:0] a_arr  [NREQ];
    logic [7:0] b_arr  [NREQ];
    logic [2:0] op_arr [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign a_arr[g]  = req_a_i[g*8 +: 8];
        assign b_arr[g]  = req_b_i[g*8 +: 8];
        assign op_arr[g] = req_op_i[g*3 +: 3];
    end

    // Round-robin pick: first set bit scanning up from rr_ptr_q, wrapping.
    logic           win_found;
    logic [IDW-1:0] win_idx;
    logic [IDW-1:0] rr_ptr_d;
    int             scan_idx;

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = 0;
        for (int k = 0; k < NREQ; k++) begin
            scan_idx = int'(rr_ptr_q) + k;
            if (scan_idx >= NREQ) scan_idx = scan_idx - NREQ;
            if (!win_found && req_i[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = IDW'(scan_idx);
            end
        end
    end

    assign rr_ptr_d = (win_idx == IDW'(NREQ - 1)) ? '0 : win_idx + 1'b1;

    // Grant goes out in the same IDLE cycle the operands are captured, so the
    // requester may drop or reassert req on the very next cycle.
    always_comb begin
        grant_o = '0;
        if (!reset_i && state_q == S_IDLE && win_found) grant_o[win_idx] = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= S_IDLE;
            rr_ptr_q     <= '0;
            id_q         <= '0;
            cnt_q        <= '0;
            alu_start_q  <= 1'b0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= '0;
            rsp_valid_q  <= '0;
            rsp_result_q <= '0;
            rsp_error_q  <= 1'b0;
            spurious_q   <= 1'b0;
        end else begin
            // Response signals are pulses; default them low every cycle.
            rsp_valid_q  <= '0;
            rsp_result_q <= '0;
            rsp_error_q  <= 1'b0;

            if (alu_done_i && state_q != S_ISSUE) spurious_q <= 1'b1;

            case (state_q)
                S_IDLE: begin
                    if (win_found) begin
                        id_q     <= win_idx;
                        rr_ptr_q <= rr_ptr_d;
                        cnt_q    <= '0;
                        if (op_arr[win_idx] != 3'd0) begin
                            // Operands only change here, while alu_start is low.
                            alu_a_q     <= a_arr[win_idx];
                            alu_b_q     <= b_arr[win_idx];
                            alu_op_q    <= op_arr[win_idx];
                            alu_start_q <= 1'b1;
                            state_q     <= S_ISSUE;
                        end else begin
                            // no_op never touches the ALU; answer 0 directly.
                            rsp_valid_q[win_idx] <= 1'b1;
                            state_q              <= S_RESP;
                        end
                    end
                end

                S_ISSUE: begin
                    cnt_q <= cnt_q + 1'b1;
                    // done is checked first so it wins over a same-cycle timeout.
                    if (alu_done_i) begin
                        alu_start_q       <= 1'b0;
                        rsp_valid_q[id_q] <= 1'b1;
                        rsp_result_q      <= alu_result_i;
                        state_q           <= S_RESP;
                    end else if (cnt_q == CW'(TIMEOUT)) begin
                        alu_start_q       <= 1'b0;
                        rsp_valid_q[id_q] <= 1'b1;
                        rsp_error_q       <= 1'b1;
                        state_q           <= S_RESP;
                    end
                end

                S_RESP: begin
                    cnt_q   <= '0;
                    state_q <= S_IDLE;
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign alu_start_o     = alu_start_q;
    assign alu_a_o         = alu_a_q;
    assign alu_b_o         = alu_b_q;
    assign alu_op_o        = alu_op_q;
    assign rsp_valid_o     = rsp_valid_q;
    assign rsp_result_o    = rsp_result_q;
    assign rsp_error_o     = rsp_error_q;
    assign busy_o          = (state_q != S_IDLE);
    assign spurious_done_o = spurious_q;

endmodule

// File: tb/tb_tinyalu_arbiter.sv
module tb_tinyalu_arbiter;

    localparam int NREQ    = 4;
    localparam int TIMEOUT = 31;

    logic             clk = 1'b0;
    logic             reset;
    logic [NREQ-1:0]  req;
    logic [8*NREQ-1:0] req_a, req_b;
    logic [3*NREQ-1:0] req_op;
    logic [NREQ-1:0]  grant, rsp_valid;
    logic [15:0]      rsp_result;
    logic             rsp_error, alu_start;
    logic [7:0]       alu_a, alu_b;
    logic [2:0]       alu_op;
    logic             alu_done;
    logic [15:0]      alu_result;
    logic             busy, spurious_done;

    tinyalu_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk), .reset_i(reset), .req_i(req), .req_a_i(req_a), .req_b_i(req_b),
        .req_op_i(req_op), .grant_o(grant), .rsp_valid_o(rsp_valid),
        .rsp_result_o(rsp_result), .rsp_error_o(rsp_error), .alu_start_o(alu_start),
        .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_op_o(alu_op), .alu_done_i(alu_done),
        .alu_result_i(alu_result), .busy_o(busy), .spurious_done_o(spurious_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [15:0] res;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // ---------------- TinyALU environment model ----------------
    bit model_en = 1'b1;
    bit hang     = 1'b0;
    int lat      = 2;
    int mcyc     = 0;

    function automatic logic [15:0] alu_fn(logic [7:0] a, logic [7:0] b, logic [2:0] op);
        case (op)
            3'd1:    return 16'(a) + 16'(b);
            3'd2:    return {8'h00, a & b};
            3'd3:    return {8'h00, a ^ b};
            3'd4:    return 16'(a) * 16'(b);
            default: return 16'hBEEF;
        endcase
    endfunction

    always @(negedge clk) begin
        if (model_en) begin
            if (alu_start && !alu_done) begin
                mcyc = mcyc + 1;
                if (!hang && mcyc >= lat) begin
                    alu_done   = 1'b1;
                    alu_result = alu_fn(alu_a, alu_b, alu_op);
                end
            end else begin
                alu_done = 1'b0;
                mcyc     = 0;
            end
        end
    end

    // ---------------- ALU-side firewall monitor ----------------
    int         fw_err   = 0;
    int         run      = 0;
    int         last_run = 0;
    logic       prev_start = 1'b0, prev_done = 1'b0;
    logic [18:0] prev_ops  = '0;

    always @(negedge clk) begin
        #3;
        if (prev_start && alu_start && ({alu_a, alu_b, alu_op} !== prev_ops)) fw_err = fw_err + 1;
        if (prev_start && prev_done && alu_start) fw_err = fw_err + 1;
        prev_start = alu_start;
        prev_done  = alu_done;
        prev_ops   = {alu_a, alu_b, alu_op};
        if (alu_start) run = run + 1;
        else begin
            if (run != 0) last_run = run;
            run = 0;
        end
    end

    // ---------------- helpers (no comparisons inside) ----------------
    task automatic clear_req();
        req = '0; req_a = '0; req_b = '0; req_op = '0;
    endtask

    task automatic set_req(int i, logic [7:0] a, logic [7:0] b, logic [2:0] op);
        req[i]          = 1'b1;
        req_a[i*8 +: 8] = a;
        req_b[i*8 +: 8] = b;
        req_op[i*3 +: 3] = op;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        clear_req();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        sb.delete();
        @(negedge clk);
    endtask

    task automatic wait_grant(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            #1;
            if (grant !== '0) ok = 1'b1;
        end
    endtask

    task automatic wait_rsp(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            #1;
            if (rsp_valid !== '0) ok = 1'b1;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        clear_req();
        repeat (3) @(negedge clk);
        set_req(0, 8'h11, 8'h22, 3'd1);
        set_req(3, 8'h11, 8'h22, 3'd1);
        #1;
        total++;
        if ({alu_start, busy, rsp_error, spurious_done} !== 4'b0000) begin
            bad++; $display("FAIL reset_ctl: got start/busy/err/spur=%b want 0000", {alu_start, busy, rsp_error, spurious_done});
        end
        total++;
        if ({grant, rsp_valid} !== 8'h00) begin
            bad++; $display("FAIL reset_pulses: got grant=%b rsp_valid=%b want 0", grant, rsp_valid);
        end
        total++;
        if ({rsp_result, alu_a, alu_b, alu_op} !== 35'd0) begin
            bad++; $display("FAIL reset_data: got res=%h a=%h b=%h op=%h want 0", rsp_result, alu_a, alu_b, alu_op);
        end
        clear_req();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_add();
        exp_t e;
        bit   ok;
        lat = 3; hang = 0;
        repeat (2) @(negedge clk);
        set_req(2, 8'h12, 8'h34, 3'd1);
        #1;
        total++;
        if (grant !== 4'b0100) begin bad++; $display("FAIL add_grant: got %b want 0100", grant); end
        sb.push_back('{2, 16'h0046, 1'b0});
        @(negedge clk);
        clear_req();
        #1;
        total++;
        if ({grant, alu_start, alu_a, alu_b, alu_op} !== {4'b0000, 1'b1, 8'h12, 8'h34, 3'd1}) begin
            bad++; $display("FAIL add_issue: got grant=%b start=%b a=%h b=%h op=%0d want 0000 1 12 34 1",
                            grant, alu_start, alu_a, alu_b, alu_op);
        end
        wait_rsp(ok);
        total++;
        if (!ok) begin bad++; $display("FAIL add_wait: got no rsp_valid want one within 100 cycles"); end
        e = sb.pop_front();
        total++;
        if ({rsp_valid, rsp_result, rsp_error} !== {4'(1 << e.id), e.res, e.err}) begin
            bad++; $display("FAIL add_rsp: got v=%b r=%h e=%b want v=%b r=%h e=%b",
                            rsp_valid, rsp_result, rsp_error, 4'(1 << e.id), e.res, e.err);
        end
        @(negedge clk);
        total++;
        if ({rsp_valid, alu_start, busy} !== 6'b0) begin
            bad++; $display("FAIL add_after: got v=%b start=%b busy=%b want 0", rsp_valid, alu_start, busy);
        end
    endtask

    task automatic test_round_robin();
        exp_t       e;
        bit         ok;
        int         id;
        logic [7:0] a, b;
        do_reset();
        lat = 2; hang = 0;
        for (int i = 0; i < NREQ; i++) set_req(i, 8'(i + 3), 8'(2 * i + 5), 3'd4);
        #1;
        for (int n = 0; n < 5; n++) begin
            id = n % NREQ;
            if (n > 0) begin
                wait_grant(ok);
                total++;
                if (!ok) begin bad++; $display("FAIL rr_wait_grant: got no grant want one at step %0d", n); end
            end
            total++;
            if (grant !== 4'(1 << id)) begin
                bad++; $display("FAIL rr_grant: step %0d got %b want %b", n, grant, 4'(1 << id));
            end
            a = 8'(id + 3);
            b = 8'(2 * id + 5);
            sb.push_back('{id, 16'(a) * 16'(b), 1'b0});
            if (n == 4) begin @(negedge clk); clear_req(); end
            wait_rsp(ok);
            total++;
            if (!ok) begin bad++; $display("FAIL rr_wait_rsp: got no rsp want one at step %0d", n); end
            e = sb.pop_front();
            total++;
            if ({rsp_valid, rsp_result, rsp_error} !== {4'(1 << e.id), e.res, e.err}) begin
                bad++; $display("FAIL rr_rsp: step %0d got v=%b r=%h e=%b want v=%b r=%h e=%b",
                                n, rsp_valid, rsp_result, rsp_error, 4'(1 << e.id), e.res, e.err);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_ops();
        logic [2:0] ops [3] = '{3'd2, 3'd3, 3'd7};
        logic [15:0] want [3] = '{16'h0030, 16'h00CC, 16'hBEEF};
        exp_t e;
        bit   ok;
        lat = 1; hang = 0;
        for (int k = 0; k < 3; k++) begin
            repeat (2) @(negedge clk);
            set_req(3, 8'hF0, 8'h3C, ops[k]);
            #1;
            total++;
            if (grant !== 4'b1000) begin bad++; $display("FAIL ops_grant: op %0d got %b want 1000", ops[k], grant); end
            sb.push_back('{3, want[k], 1'b0});
            @(negedge clk);
            clear_req();
            total++;
            if ({alu_start, alu_op} !== {1'b1, ops[k]}) begin
                bad++; $display("FAIL ops_issue: got start=%b op=%0d want 1 %0d", alu_start, alu_op, ops[k]);
            end
            wait_rsp(ok);
            e = sb.pop_front();
            total++;
            if (!ok || {rsp_valid, rsp_result, rsp_error} !== {4'(1 << e.id), e.res, e.err}) begin
                bad++; $display("FAIL ops_rsp: op %0d got v=%b r=%h e=%b want v=%b r=%h e=%b",
                                ops[k], rsp_valid, rsp_result, rsp_error, 4'(1 << e.id), e.res, e.err);
            end
        end
    endtask

    task automatic test_noop();
        exp_t e;
        repeat (2) @(negedge clk);
        set_req(1, 8'hAA, 8'h55, 3'd0);
        #1;
        total++;
        if ({grant, alu_start} !== {4'b0010, 1'b0}) begin
            bad++; $display("FAIL noop_grant: got grant=%b start=%b want 0010 0", grant, alu_start);
        end
        sb.push_back('{1, 16'h0000, 1'b0});
        @(negedge clk);
        clear_req();
        #1;
        e = sb.pop_front();
        total++;
        if ({rsp_valid, rsp_result, rsp_error, alu_start} !== {4'(1 << e.id), e.res, e.err, 1'b0}) begin
            bad++; $display("FAIL noop_rsp: got v=%b r=%h e=%b start=%b want v=%b r=%h e=%b start=0",
                            rsp_valid, rsp_result, rsp_error, alu_start, 4'(1 << e.id), e.res, e.err);
        end
        @(negedge clk);
    endtask

    task automatic test_timeout();
        exp_t e;
        bit   ok;
        // Pass 0: ALU never answers. Pass 1: done lands on the timeout cycle.
        for (int pass = 0; pass < 2; pass++) begin
            hang = (pass == 0);
            lat  = TIMEOUT + 1;
            repeat (2) @(negedge clk);
            set_req(0, 8'h07, 8'h09, 3'd1);
            #1;
            sb.push_back('{0, (pass == 0) ? 16'h0000 : 16'h0010, (pass == 0)});
            @(negedge clk);
            clear_req();
            wait_rsp(ok);
            e = sb.pop_front();
            total++;
            if (!ok || {rsp_valid, rsp_result, rsp_error} !== {4'(1 << e.id), e.res, e.err}) begin
                bad++; $display("FAIL to_rsp: pass %0d got v=%b r=%h e=%b want v=%b r=%h e=%b",
                                pass, rsp_valid, rsp_result, rsp_error, 4'(1 << e.id), e.res, e.err);
            end
            @(negedge clk);
            total++;
            if ({busy, alu_start} !== 2'b00 || last_run != TIMEOUT + 1) begin
                bad++; $display("FAIL to_start_len: pass %0d got busy=%b start=%b run=%0d want 0 0 %0d",
                                pass, busy, alu_start, last_run, TIMEOUT + 1);
            end
        end
        hang = 0;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        bit   ok;
        do_reset();
        lat = 2; hang = 0;
        fw_err = 0;
        set_req(0, 8'hFF, 8'hFF, 3'd4);
        set_req(1, 8'hFF, 8'hFF, 3'd4);
        #1;
        total++;
        if (grant !== 4'b0001) begin bad++; $display("FAIL b2b_grant0: got %b want 0001", grant); end
        sb.push_back('{0, 16'hFE01, 1'b0});
        @(negedge clk);
        req[0] = 1'b0;
        wait_rsp(ok);
        e = sb.pop_front();
        total++;
        if (!ok || {rsp_valid, rsp_result, rsp_error} !== {4'(1 << e.id), e.res, e.err}) begin
            bad++; $display("FAIL b2b_rsp0: got v=%b r=%h e=%b want v=%b r=%h e=%b",
                            rsp_valid, rsp_result, rsp_error, 4'(1 << e.id), e.res, e.err);
        end
        wait_grant(ok);
        total++;
        if (!ok || grant !== 4'b0010) begin bad++; $display("FAIL b2b_grant1: got %b want 0010", grant); end
        sb.push_back('{1, 16'hFE01, 1'b0});
        @(negedge clk);
        clear_req();
        wait_rsp(ok);
        e = sb.pop_front();
        total++;
        if (!ok || {rsp_valid, rsp_result, rsp_error} !== {4'(1 << e.id), e.res, e.err}) begin
            bad++; $display("FAIL b2b_rsp1: got v=%b r=%h e=%b want v=%b r=%h e=%b",
                            rsp_valid, rsp_result, rsp_error, 4'(1 << e.id), e.res, e.err);
        end
        repeat (2) @(negedge clk);
        total++;
        if (fw_err != 0) begin bad++; $display("FAIL b2b_firewall: got %0d violations want 0", fw_err); end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int   seen = 0;
        hang = 1;
        repeat (2) @(negedge clk);
        set_req(2, 8'h01, 8'h02, 3'd1);
        #1;
        sb.push_back('{2, 16'h0003, 1'b0});
        @(negedge clk);
        clear_req();
        repeat (5) @(negedge clk);
        reset = 1'b1;
        sb.delete();
        @(negedge clk);
        #1;
        total++;
        if ({alu_start, busy, rsp_valid} !== 6'b0) begin
            bad++; $display("FAIL rst_mid: got start=%b busy=%b v=%b want 0 0 0", alu_start, busy, rsp_valid);
        end
        reset = 1'b0;
        hang  = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rsp_valid !== '0) seen++;
        end
        total++;
        if (seen != 0) begin bad++; $display("FAIL rst_no_rsp: got %0d responses want 0", seen); end
        for (int i = 0; i < NREQ; i++) set_req(i, 8'h00, 8'h00, 3'd0);
        #1;
        total++;
        if (grant !== 4'b0001) begin bad++; $display("FAIL rst_rrptr: got grant=%b want 0001", grant); end
        sb.push_back('{0, 16'h0000, 1'b0});
        @(negedge clk);
        clear_req();
        e = sb.pop_front();
        total++;
        if ({rsp_valid, rsp_result, rsp_error} !== {4'(1 << e.id), e.res, e.err}) begin
            bad++; $display("FAIL rst_noop_rsp: got v=%b r=%h e=%b want v=%b r=%h e=%b",
                            rsp_valid, rsp_result, rsp_error, 4'(1 << e.id), e.res, e.err);
        end
        repeat (2) @(negedge clk);
        total++;
        if (spurious_done !== 1'b0) begin bad++; $display("FAIL spur_clear: got %b want 0", spurious_done); end
        model_en = 1'b0;
        alu_done = 1'b1;
        @(negedge clk);
        alu_done = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({spurious_done, busy, rsp_valid} !== {1'b1, 1'b0, 4'b0}) begin
            bad++; $display("FAIL spur_set: got spur=%b busy=%b v=%b want 1 0 0000", spurious_done, busy, rsp_valid);
        end
        model_en = 1'b1;
    endtask

    initial begin
        reset      = 1'b1;
        alu_done   = 1'b0;
        alu_result = '0;
        clear_req();
        test_reset();
        test_single_add();
        test_round_robin();
        test_ops();
        test_noop();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
